// File: rtl/bus_pkg.sv
// Shared bus definitions: register mode codes and the default bus data width.
package bus_pkg;

   typedef enum logic [1:0] {
      BUS_MODE_RW    = 2'd0,
      BUS_MODE_RO    = 2'd1,
      BUS_MODE_W1C   = 2'd2,
      BUS_MODE_PULSE = 2'd3
   } bus_mode_e;

   localparam int unsigned BUS_DATA_WIDTH = 8;

endpackage

// File: rtl/bus_reg_cell.sv
// One register slice of the bus register bank; behaviour fixed by the MODE parameter.
module bus_reg_cell
   import bus_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = BUS_DATA_WIDTH,
   parameter bus_mode_e             MODE       = BUS_MODE_RW,
   parameter logic [DATA_WIDTH-1:0] INIT       = '0
) (
   input  logic                  i_Bus_Clk,
   input  logic                  i_Bus_Rst_L,
   input  logic                  i_Wr_En,
   input  logic [DATA_WIDTH-1:0] i_Wr_Data,
   input  logic [DATA_WIDTH-1:0] i_Set,
   input  logic [DATA_WIDTH-1:0] i_Ro_Val,
   output logic [DATA_WIDTH-1:0] o_Reg,
   output logic [DATA_WIDTH-1:0] o_Rd_Val
);

   // Only RW registers come out of reset with a programmed value.
   localparam logic [DATA_WIDTH-1:0] RST_VAL = (MODE == BUS_MODE_RW) ? INIT : '0;

   logic [DATA_WIDTH-1:0] value_q, value_d;

   // Next-state of the stored value according to the register mode.
   always_comb begin
      value_d = value_q;
      case (MODE)
         BUS_MODE_RW:    if (i_Wr_En) value_d = i_Wr_Data;
         BUS_MODE_RO:    value_d = '0;
         // Set is OR-ed last so a same-edge clear never loses it.
         BUS_MODE_W1C:   value_d = (value_q & ~(i_Wr_En ? i_Wr_Data : '0)) | i_Set;
         BUS_MODE_PULSE: value_d = i_Wr_En ? i_Wr_Data : '0;
      endcase
   end

   // Stored value register.
   always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
      if (!i_Bus_Rst_L) value_q <= RST_VAL;
      else              value_q <= value_d;
   end

   // Application-facing value and bus read-back value.
   always_comb begin
      o_Reg    = value_q;
      o_Rd_Val = value_q;
      case (MODE)
         BUS_MODE_RO: begin
            o_Reg    = i_Ro_Val;
            o_Rd_Val = i_Ro_Val;
         end
         BUS_MODE_PULSE: o_Rd_Val = '0;
         default: ;
      endcase
   end

endmodule

// File: rtl/bus_reg_bank.sv
// Parametrised bus register bank: address decode, range check, read mux and bus response.
module bus_reg_bank
   import bus_pkg::*;
#(
   parameter int unsigned                     DATA_WIDTH = BUS_DATA_WIDTH,
   parameter int unsigned                     NUM_REGS   = 4,
   parameter int unsigned                     ADDR_WIDTH = 2,
   parameter logic [2*NUM_REGS-1:0]           REG_MODES  = '0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0]  INIT       = '0
) (
   input  logic                           i_Bus_Clk,
   input  logic                           i_Bus_Rst_L,
   input  logic                           i_Bus_CS,
   input  logic                           i_Bus_Wr_Rd_n,
   input  logic [ADDR_WIDTH-1:0]          i_Bus_Addr,
   input  logic [DATA_WIDTH-1:0]          i_Bus_Wr_Data,
   output logic [DATA_WIDTH-1:0]          o_Bus_Rd_Data,
   output logic                           o_Bus_Rd_DV,
   output logic                           o_Bus_Err,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] i_Reg,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] i_Reg_Set,
   output logic [NUM_REGS*DATA_WIDTH-1:0] o_Reg,
   output logic [NUM_REGS-1:0]            o_Reg_Wr
);

   logic                  addr_valid;
   logic [NUM_REGS-1:0]   wr_en;
   logic [DATA_WIDTH-1:0] rd_val [NUM_REGS];
   logic [DATA_WIDTH-1:0] rd_sel;

   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  rd_dv_q;
   logic                  err_q;
   logic [NUM_REGS-1:0]   reg_wr_q;

   assign addr_valid = 32'(i_Bus_Addr) < NUM_REGS;

   // Address decode; an out-of-range address matches no register, so it
   // writes nothing and reads back zero.
   always_comb begin
      wr_en  = '0;
      rd_sel = '0;
      for (int unsigned n = 0; n < NUM_REGS; n++) begin
         if (32'(i_Bus_Addr) == n) begin
            wr_en[n] = i_Bus_CS & i_Bus_Wr_Rd_n;
            rd_sel   = rd_val[n];
         end
      end
   end

   // Bus response registers: read data (held between reads), DV, error and write strobes.
   always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
      if (!i_Bus_Rst_L) begin
         rd_data_q <= '0;
         rd_dv_q   <= 1'b0;
         err_q     <= 1'b0;
         reg_wr_q  <= '0;
      end else begin
         rd_dv_q  <= i_Bus_CS & ~i_Bus_Wr_Rd_n;
         err_q    <= i_Bus_CS & ~addr_valid;
         reg_wr_q <= wr_en;
         if (i_Bus_CS && !i_Bus_Wr_Rd_n) rd_data_q <= rd_sel;
      end
   end

   assign o_Bus_Rd_Data = rd_data_q;
   assign o_Bus_Rd_DV   = rd_dv_q;
   assign o_Bus_Err     = err_q;
   assign o_Reg_Wr      = reg_wr_q;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
      bus_reg_cell #(
         .DATA_WIDTH (DATA_WIDTH),
         .MODE       (bus_mode_e'(REG_MODES[2*g +: 2])),
         .INIT       (INIT[g*DATA_WIDTH +: DATA_WIDTH])
      ) u_cell (
         .i_Bus_Clk   (i_Bus_Clk),
         .i_Bus_Rst_L (i_Bus_Rst_L),
         .i_Wr_En     (wr_en[g]),
         .i_Wr_Data   (i_Bus_Wr_Data),
         .i_Set       (i_Reg_Set[g*DATA_WIDTH +: DATA_WIDTH]),
         .i_Ro_Val    (i_Reg[g*DATA_WIDTH +: DATA_WIDTH]),
         .o_Reg       (o_Reg[g*DATA_WIDTH +: DATA_WIDTH]),
         .o_Rd_Val    (rd_val[g])
      );
   end

endmodule

// File: tb/tb_bus_reg_bank.sv
// Self-checking bench for bus_reg_bank: directed vector table, randomized model check,
// and a reset-during-read sequence.
module tb_bus_reg_bank;

   logic        clk = 1'b0;
   logic        rst_l;
   logic        cs, wr;
   logic [2:0]  addr;
   logic [7:0]  wdata;
   logic [7:0]  rd_data;
   logic        rd_dv, err;
   logic [39:0] ireg, iset, oreg;
   logic [4:0]  oreg_wr;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bus_reg_bank #(
      .DATA_WIDTH (8),
      .NUM_REGS   (5),
      .ADDR_WIDTH (3),
      .REG_MODES  ({2'd0, 2'd3, 2'd2, 2'd1, 2'd0}),
      .INIT       ({8'h00, 8'h00, 8'h00, 8'h00, 8'hA5})
   ) dut (
      .i_Bus_Clk     (clk),
      .i_Bus_Rst_L   (rst_l),
      .i_Bus_CS      (cs),
      .i_Bus_Wr_Rd_n (wr),
      .i_Bus_Addr    (addr),
      .i_Bus_Wr_Data (wdata),
      .o_Bus_Rd_Data (rd_data),
      .o_Bus_Rd_DV   (rd_dv),
      .o_Bus_Err     (err),
      .i_Reg         (ireg),
      .i_Reg_Set     (iset),
      .o_Reg         (oreg),
      .o_Reg_Wr      (oreg_wr)
   );

   typedef struct {
      logic        cs;
      logic        wr;
      logic [2:0]  addr;
      logic [7:0]  wdata;
      logic [7:0]  set2;
      logic [7:0]  e_rd;
      logic        e_dv;
      logic        e_err;
      logic [4:0]  e_wr;
      logic [39:0] e_reg;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic c, input logic w, input logic [2:0] a,
                               input logic [7:0] d, input logic [7:0] s, input logic [7:0] rd,
                               input logic dv, input logic er, input logic [4:0] ew,
                               input logic [39:0] er_reg);
      vec_t v;
      v.cs = c; v.wr = w; v.addr = a; v.wdata = d; v.set2 = s;
      v.e_rd = rd; v.e_dv = dv; v.e_err = er; v.e_wr = ew; v.e_reg = er_reg;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic apply(input logic c, input logic w, input logic [2:0] a, input logic [7:0] d,
                        input logic [39:0] ir, input logic [39:0] is);
      cs = c; wr = w; addr = a; wdata = d; ireg = ir; iset = is;
      @(posedge clk);
      #1;
   endtask

   task automatic cmp_all(input string tag, input logic [7:0] e_rd, input logic e_dv,
                          input logic e_err, input logic [4:0] e_wr, input logic [39:0] e_reg);
      chk({tag, " rd_data"}, 64'(rd_data), 64'(e_rd));
      chk({tag, " rd_dv"},   64'(rd_dv),   64'(e_dv));
      chk({tag, " err"},     64'(err),     64'(e_err));
      chk({tag, " reg_wr"},  64'(oreg_wr), 64'(e_wr));
      chk({tag, " o_reg"},   64'(oreg),    64'(e_reg));
   endtask

   // Reference model state: plain per-register values.
   logic [7:0] m_r0, m_r2, m_r3, m_r4, m_rd;

   initial begin
      logic [39:0] ir_fix;
      logic [63:0] t;
      logic [7:0]  v, clr;
      logic        e_dv, e_err;
      logic [4:0]  e_wr;
      logic        rc, rw;
      logic [2:0]  ra;
      logic [7:0]  rdat;
      logic [39:0] rir, ris;

      ir_fix = {8'h11, 8'h22, 8'h33, 8'h5A, 8'h44};

      // Directed table; o_Reg expectation is {r4, r3, r2, i_Reg[1]=5A, r0}.
      tbl.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'hA5, 1, 0, 5'b00000, 40'h00_00_00_5A_A5));
      tbl.push_back(mk(1, 1, 4, 8'h3C, 8'h00, 8'hA5, 0, 0, 5'b10000, 40'h3C_00_00_5A_A5));
      tbl.push_back(mk(1, 0, 4, 8'h00, 8'h00, 8'h3C, 1, 0, 5'b00000, 40'h3C_00_00_5A_A5));
      tbl.push_back(mk(1, 1, 1, 8'hFF, 8'h00, 8'h3C, 0, 0, 5'b00010, 40'h3C_00_00_5A_A5));
      tbl.push_back(mk(1, 0, 1, 8'h00, 8'h00, 8'h5A, 1, 0, 5'b00000, 40'h3C_00_00_5A_A5));
      tbl.push_back(mk(0, 0, 0, 8'h00, 8'h81, 8'h5A, 0, 0, 5'b00000, 40'h3C_00_81_5A_A5));
      tbl.push_back(mk(1, 0, 2, 8'h00, 8'h00, 8'h81, 1, 0, 5'b00000, 40'h3C_00_81_5A_A5));
      tbl.push_back(mk(1, 1, 2, 8'h01, 8'h00, 8'h81, 0, 0, 5'b00100, 40'h3C_00_80_5A_A5));
      tbl.push_back(mk(1, 0, 2, 8'h00, 8'h00, 8'h80, 1, 0, 5'b00000, 40'h3C_00_80_5A_A5));
      tbl.push_back(mk(1, 1, 2, 8'h80, 8'h80, 8'h80, 0, 0, 5'b00100, 40'h3C_00_80_5A_A5));
      tbl.push_back(mk(1, 0, 2, 8'h00, 8'h00, 8'h80, 1, 0, 5'b00000, 40'h3C_00_80_5A_A5));
      tbl.push_back(mk(1, 1, 3, 8'h0F, 8'h00, 8'h80, 0, 0, 5'b01000, 40'h3C_0F_80_5A_A5));
      tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h80, 0, 0, 5'b00000, 40'h3C_00_80_5A_A5));
      tbl.push_back(mk(1, 0, 3, 8'h00, 8'h00, 8'h00, 1, 0, 5'b00000, 40'h3C_00_80_5A_A5));
      tbl.push_back(mk(1, 0, 6, 8'h00, 8'h00, 8'h00, 1, 1, 5'b00000, 40'h3C_00_80_5A_A5));
      tbl.push_back(mk(1, 1, 7, 8'hFF, 8'h00, 8'h00, 0, 1, 5'b00000, 40'h3C_00_80_5A_A5));
      tbl.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'hA5, 1, 0, 5'b00000, 40'h3C_00_80_5A_A5));
      tbl.push_back(mk(1, 0, 1, 8'h00, 8'h00, 8'h5A, 1, 0, 5'b00000, 40'h3C_00_80_5A_A5));
      tbl.push_back(mk(1, 0, 2, 8'h00, 8'h00, 8'h80, 1, 0, 5'b00000, 40'h3C_00_80_5A_A5));
      tbl.push_back(mk(1, 0, 3, 8'h00, 8'h00, 8'h00, 1, 0, 5'b00000, 40'h3C_00_80_5A_A5));
      tbl.push_back(mk(1, 0, 4, 8'h00, 8'h00, 8'h3C, 1, 0, 5'b00000, 40'h3C_00_80_5A_A5));
      tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h3C, 0, 0, 5'b00000, 40'h3C_00_80_5A_A5));

      // Reset state.
      rst_l = 1'b0;
      cs = 1'b0; wr = 1'b0; addr = '0; wdata = '0; ireg = ir_fix; iset = '0;
      #23;
      cmp_all("reset", 8'h00, 1'b0, 1'b0, 5'b00000, 40'h00_00_00_5A_A5);
      rst_l = 1'b1;

      // Directed vectors; set pulses in other slices must not reach anything.
      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i].cs, tbl[i].wr, tbl[i].addr, tbl[i].wdata, ir_fix,
               {8'hC3, 8'hC3, tbl[i].set2, 8'hC3, 8'hC3});
         cmp_all($sformatf("tbl[%0d]", i), tbl[i].e_rd, tbl[i].e_dv, tbl[i].e_err,
                 tbl[i].e_wr, tbl[i].e_reg);
      end

      // Randomized traffic against the behavioural model.
      m_r0 = 8'hA5; m_r2 = 8'h80; m_r3 = 8'h00; m_r4 = 8'h3C; m_rd = 8'h3C;
      for (int i = 0; i < 400; i++) begin
         rc   = 1'($urandom_range(0, 3) != 0);
         rw   = 1'($urandom_range(0, 1));
         ra   = 3'($urandom_range(0, 7));
         rdat = 8'($urandom);
         t    = {$urandom, $urandom};
         rir  = t[39:0];
         t    = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
         ris  = t[39:0];

         case (ra)
            3'd0:    v = m_r0;
            3'd1:    v = rir[15:8];
            3'd2:    v = m_r2;
            3'd4:    v = m_r4;
            default: v = 8'h00;
         endcase
         e_dv  = rc && !rw;
         e_err = rc && (ra > 3'd4);
         e_wr  = '0;
         if (rc && rw && ra <= 3'd4) e_wr[ra] = 1'b1;
         if (e_dv) m_rd = v;
         clr  = (rc && rw && ra == 3'd2) ? rdat : 8'h00;
         m_r2 = (m_r2 & ~clr) | ris[23:16];
         m_r3 = (rc && rw && ra == 3'd3) ? rdat : 8'h00;
         if (rc && rw && ra == 3'd0) m_r0 = rdat;
         if (rc && rw && ra == 3'd4) m_r4 = rdat;

         apply(rc, rw, ra, rdat, rir, ris);
         cmp_all($sformatf("rnd[%0d]", i), m_rd, e_dv, e_err, e_wr,
                 {m_r4, m_r3, m_r2, rir[15:8], m_r0});
      end

      // Reset asserted while an out-of-range read is in flight: no DV, no error.
      cs = 1'b1; wr = 1'b0; addr = 3'd6; ireg = ir_fix; iset = '0;
      #2;
      rst_l = 1'b0;
      @(posedge clk);
      #1;
      cmp_all("rst_mid_read", 8'h00, 1'b0, 1'b0, 5'b00000, 40'h00_00_00_5A_A5);
      cs = 1'b0;
      #2;
      rst_l = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_after dv", 64'(rd_dv), 64'(0));
      chk("rst_after err", 64'(err), 64'(0));

      // RW register back at its reset value.
      apply(1'b1, 1'b0, 3'd4, 8'h00, ir_fix, 40'h0);
      cmp_all("rst_readback", 8'h00, 1'b1, 1'b0, 5'b00000, 40'h00_00_00_5A_A5);
      cs = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
